// File: rtl/rpn_calc_stack.sv
// rpn_calc_stack: RPN calculator with an integrated LIFO operand stack.
// Tokens arrive over an input stb/ack pair; POP results leave over an output stb/ack pair.
module rpn_calc_stack #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_stb,
    input  logic [DATA_W-1:0] input_dat,
    input  logic              input_operator,
    output logic              input_ack,
    output logic              output_stb,
    output logic [DATA_W-1:0] output_dat,
    input  logic              output_ack,
    output logic [CNT_W-1:0]  depth,
    output logic              err_underflow,
    output logic              err_overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_OUT_WAIT,
        S_ACK
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MUL  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_POP  = 3'd4,
        OP_DUP  = 3'd5,
        OP_SWAP = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    state_e              state_q;
    logic [CNT_W-1:0]    depth_q;
    logic                uf_q;
    logic                of_q;
    logic                in_ack_q;
    logic                out_stb_q;
    logic [DATA_W-1:0]   out_dat_q;
    logic [DATA_W-1:0]   tok_dat_q;
    logic                tok_op_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    op_e                 op;
    logic [CNT_W-1:0]    t_idx;
    logic [CNT_W-1:0]    s_idx;
    logic [DATA_W-1:0]   t_val;
    logic [DATA_W-1:0]   s_val;
    logic [DATA_W-1:0]   alu;
    logic                empty;
    logic                lt2;
    logic                full;
    logic                exec_uf;
    logic                exec_of;
    logic [CNT_W-1:0]    exec_depth_d;

    assign input_ack     = in_ack_q;
    assign output_stb    = out_stb_q;
    assign output_dat    = out_dat_q;
    assign depth         = depth_q;
    assign err_underflow = uf_q;
    assign err_overflow  = of_q;

    // Decode of the latched token against the current stack depth.
    always_comb begin
        op           = op_e'(tok_dat_q[2:0]);
        t_idx        = depth_q - CNT_W'(1);
        s_idx        = depth_q - CNT_W'(2);
        t_val        = mem_q[t_idx[AW-1:0]];
        s_val        = mem_q[s_idx[AW-1:0]];
        empty        = (depth_q == '0);
        lt2          = (depth_q < CNT_W'(2));
        full         = (depth_q == CNT_W'(DEPTH));
        alu          = '0;
        exec_uf      = 1'b0;
        exec_of      = 1'b0;
        exec_depth_d = depth_q;
        if (!tok_op_q) begin
            if (full) exec_of = 1'b1;
            else      exec_depth_d = depth_q + CNT_W'(1);
        end else begin
            unique case (op)
                OP_MUL, OP_ADD, OP_SUB: begin
                    unique case (op)
                        OP_MUL:  alu = s_val * t_val;
                        OP_ADD:  alu = s_val + t_val;
                        default: alu = s_val - t_val;
                    endcase
                    if (lt2) exec_uf = 1'b1;
                    else     exec_depth_d = depth_q - CNT_W'(1);
                end
                OP_POP: begin
                    if (empty) exec_uf = 1'b1;
                end
                OP_DUP: begin
                    if (empty)     exec_uf = 1'b1;
                    else if (full) exec_of = 1'b1;
                    else           exec_depth_d = depth_q + CNT_W'(1);
                end
                OP_SWAP: begin
                    if (lt2) exec_uf = 1'b1;
                end
                OP_CLR: begin
                    exec_depth_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Stack storage has no reset; entries above depth are don't-care.
    always_ff @(posedge clk) begin
        if (state_q == S_EXEC && !exec_uf && !exec_of) begin
            if (!tok_op_q) begin
                mem_q[depth_q[AW-1:0]] <= tok_dat_q;
            end else begin
                case (op)
                    OP_MUL, OP_ADD, OP_SUB: mem_q[s_idx[AW-1:0]] <= alu;
                    OP_DUP:                 mem_q[depth_q[AW-1:0]] <= t_val;
                    OP_SWAP: begin
                        mem_q[t_idx[AW-1:0]] <= s_val;
                        mem_q[s_idx[AW-1:0]] <= t_val;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            depth_q   <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            in_ack_q  <= 1'b0;
            out_stb_q <= 1'b0;
            out_dat_q <= '0;
            tok_dat_q <= '0;
            tok_op_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (input_stb) begin
                        tok_dat_q <= input_dat;
                        tok_op_q  <= input_operator;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    depth_q <= exec_depth_d;
                    if (exec_uf) uf_q <= 1'b1;
                    if (exec_of) of_q <= 1'b1;
                    if (tok_op_q && op == OP_CLR) begin
                        uf_q <= 1'b0;
                        of_q <= 1'b0;
                    end
                    // A valid POP keeps its entry until the consumer accepts it.
                    if (tok_op_q && op == OP_POP && !empty) begin
                        out_dat_q <= t_val;
                        out_stb_q <= 1'b1;
                        state_q   <= S_OUT_WAIT;
                    end else begin
                        in_ack_q  <= 1'b1;
                        state_q   <= S_ACK;
                    end
                end
                S_OUT_WAIT: begin
                    if (output_ack) begin
                        out_stb_q <= 1'b0;
                        depth_q   <= depth_q - CNT_W'(1);
                        in_ack_q  <= 1'b1;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    in_ack_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_calc_stack.sv
// Bench for rpn_calc_stack: fixed vector table, corner-case sequences and
// random tokens checked against a queue-based stack model.
module tb_rpn_calc_stack;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int CW  = $clog2(DEP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          input_stb = 1'b0;
    logic [DW-1:0] input_dat = '0;
    logic          input_operator = 1'b0;
    logic          input_ack;
    logic          output_stb;
    logic [DW-1:0] output_dat;
    logic          output_ack = 1'b0;
    logic [CW-1:0] depth;
    logic          err_underflow;
    logic          err_overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mstk[$];
    bit            m_uf = 1'b0;
    bit            m_of = 1'b0;

    typedef struct {
        bit          isop;
        logic [31:0] dat;
        int          dly;
        bit          eg;
        logic [31:0] eo;
        int          ed;
        bit          euf;
        bit          eof;
    } vec_t;

    vec_t tbl[$];

    rpn_calc_stack #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_stb      (input_stb),
        .input_dat      (input_dat),
        .input_operator (input_operator),
        .input_ack      (input_ack),
        .output_stb     (output_stb),
        .output_dat     (output_dat),
        .output_ack     (output_ack),
        .depth          (depth),
        .err_underflow  (err_underflow),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit isop, input logic [31:0] dat, input int dly,
                                input bit eg, input logic [31:0] eo, input int ed,
                                input bit euf, input bit eof);
        vec_t v;
        v.isop = isop; v.dat = dat; v.dly = dly; v.eg = eg;
        v.eo = eo; v.ed = ed; v.euf = euf; v.eof = eof;
        return v;
    endfunction

    // Presents one token and services a POP result after ack_dly waiting cycles.
    task automatic send(input bit isop, input logic [DW-1:0] dat, input int ack_dly,
                        output bit got, output logic [DW-1:0] val,
                        output int lat, output bit unstable);
        int            cnt;
        int            wait_n;
        bit            done;
        logic [CW-1:0] d0;
        got = 0; val = '0; lat = 0; unstable = 0; done = 0;
        cnt = 0; wait_n = 0; d0 = '0;
        @(negedge clk);
        input_stb = 1'b1; input_dat = dat; input_operator = isop;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
            output_ack = 1'b0;
            if (input_ack) begin
                done = 1; lat = cnt; input_stb = 1'b0;
            end else if (output_stb) begin
                if (!got) begin
                    got = 1; val = output_dat; d0 = depth;
                end else if (output_dat !== val || depth !== d0) begin
                    unstable = 1;
                end
                if (wait_n >= ack_dly) output_ack = 1'b1;
                wait_n++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no input_ack expected input_ack within 200 cycles");
            input_stb = 1'b0; output_ack = 1'b0;
        end else begin
            @(negedge clk);
            check("ack_pulse_width", input_ack, 1'b0);
        end
    endtask

    task automatic model_apply(input bit isop, input logic [DW-1:0] dat,
                               output bit eg, output logic [DW-1:0] eo);
        logic [DW-1:0] t, s, r;
        int sz;
        eg = 0; eo = '0; sz = mstk.size(); r = '0;
        if (!isop) begin
            if (sz == DEP) m_of = 1;
            else           mstk.push_back(dat);
        end else begin
            case (dat[2:0])
                3'd1, 3'd2, 3'd3: begin
                    if (sz < 2) m_uf = 1;
                    else begin
                        t = mstk.pop_back();
                        s = mstk.pop_back();
                        if (dat[2:0] == 3'd1)      r = s * t;
                        else if (dat[2:0] == 3'd2) r = s + t;
                        else                       r = s - t;
                        mstk.push_back(r);
                    end
                end
                3'd4: begin
                    if (sz == 0) m_uf = 1;
                    else begin eg = 1; eo = mstk.pop_back(); end
                end
                3'd5: begin
                    if (sz == 0)        m_uf = 1;
                    else if (sz == DEP) m_of = 1;
                    else                mstk.push_back(mstk[sz-1]);
                end
                3'd6: begin
                    if (sz < 2) m_uf = 1;
                    else begin
                        t = mstk[sz-1]; mstk[sz-1] = mstk[sz-2]; mstk[sz-2] = t;
                    end
                end
                3'd7: begin
                    mstk.delete(); m_uf = 0; m_of = 0;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        bit            got, uns, eg;
        logic [DW-1:0] val, eo, tmp;
        int            lat, cyc, quiet_bad;

        // Hand-derived vectors: {isop, dat, ack delay, got, out, depth, uf, of}
        tbl.push_back(mk(0, 32'd7,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 32'd5,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd3,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd4,        0, 1, 32'd2,        0, 0, 0));
        tbl.push_back(mk(0, 32'd0,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 32'd1,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd3,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd4,        1, 1, 32'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk(0, 32'h10000,    0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 32'h10000,    0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd1,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd4,        0, 1, 32'd0,        0, 0, 0));
        tbl.push_back(mk(0, 32'd3,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd2,        0, 0, 0,            1, 1, 0));
        tbl.push_back(mk(1, 32'd0,        0, 0, 0,            1, 1, 0));
        tbl.push_back(mk(1, 32'd7,        0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'd4,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd5,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd6,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd1,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd4,        5, 1, 32'd16,       0, 0, 0));
        tbl.push_back(mk(1, 32'd4,        0, 0, 0,            0, 1, 0));
        tbl.push_back(mk(1, 32'd7,        0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'd10,       0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 32'd3,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd6,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'd3,        0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'd4,        2, 1, 32'hFFFFFFF9, 0, 0, 0));
        tbl.push_back(mk(0, 32'hFFFFFFFF, 0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 32'd2,        0, 0, 0,            2, 0, 0));
        tbl.push_back(mk(1, 32'hFFFFFFF2, 0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 32'hABCD0004, 0, 1, 32'd1,        0, 0, 0));

        repeat (3) @(negedge clk);
        check("rst_depth",      32'(depth),  0);
        check("rst_input_ack",  input_ack,   0);
        check("rst_output_stb", output_stb,  0);
        check("rst_output_dat", output_dat,  0);
        check("rst_uf",         err_underflow, 0);
        check("rst_of",         err_overflow,  0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            send(tbl[i].isop, tbl[i].dat, tbl[i].dly, got, val, lat, uns);
            check($sformatf("row%0d_got", i),   got, tbl[i].eg);
            if (tbl[i].eg) begin
                check($sformatf("row%0d_out", i),      val, tbl[i].eo);
                check($sformatf("row%0d_stable", i),   uns, 0);
                check($sformatf("row%0d_latency", i),  lat, 3 + tbl[i].dly);
            end else begin
                check($sformatf("row%0d_latency", i),  lat, 2);
            end
            check($sformatf("row%0d_depth", i), 32'(depth),    tbl[i].ed);
            check($sformatf("row%0d_uf", i),    err_underflow, tbl[i].euf);
            check($sformatf("row%0d_of", i),    err_overflow,  tbl[i].eof);
        end

        // Fill to capacity, then overflow by number push.
        for (int v = 1; v <= DEP; v++) send(0, 32'(v), 0, got, val, lat, uns);
        check("full_depth", 32'(depth), DEP);
        check("full_of_clear", err_overflow, 0);
        send(0, 32'd99, 0, got, val, lat, uns);
        check("ovf_push_of",    err_overflow, 1);
        check("ovf_push_depth", 32'(depth), DEP);
        check("ovf_push_lat",   lat, 2);
        send(1, 32'd4, 0, got, val, lat, uns);
        check("ovf_pop_got",   got, 1);
        check("ovf_pop_val",   val, 32'd16);
        check("ovf_pop_depth", 32'(depth), DEP - 1);
        send(1, 32'd7, 0, got, val, lat, uns);
        check("clr_of", err_overflow, 0);

        // Overflow by DUP.
        for (int v = 1; v <= DEP; v++) send(0, 32'(v * 3), 0, got, val, lat, uns);
        send(1, 32'd5, 0, got, val, lat, uns);
        check("ovf_dup_of",    err_overflow, 1);
        check("ovf_dup_uf",    err_underflow, 0);
        check("ovf_dup_depth", 32'(depth), DEP);
        send(1, 32'd4, 0, got, val, lat, uns);
        check("ovf_dup_top", val, 32'd48);
        send(1, 32'd7, 0, got, val, lat, uns);

        // Reset while a POP result is waiting for the consumer.
        send(0, 32'd9, 0, got, val, lat, uns);
        @(negedge clk);
        input_stb = 1'b1; input_dat = 32'd4; input_operator = 1'b1;
        cyc = 0;
        while (!output_stb && cyc < 20) begin @(negedge clk); cyc++; end
        check("rst_ow_stb_seen", output_stb, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_ow_stb_drop", output_stb, 0);
        check("rst_ow_depth",    32'(depth), 0);
        input_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        repeat (4) begin @(negedge clk); if (input_ack !== 1'b0) quiet_bad++; end
        check("rst_ow_no_ack", quiet_bad, 0);
        mstk.delete(); m_uf = 0; m_of = 0;
        send(0, 32'd5, 0, got, val, lat, uns);
        check("rst_ow_next_depth", 32'(depth), 1);
        check("rst_ow_next_lat",   lat, 2);

        // Random tokens against the stack model.
        send(1, 32'd7, 0, got, val, lat, uns);
        mstk.delete(); m_uf = 0; m_of = 0;
        for (int n = 0; n < 400; n++) begin
            bit            isop;
            logic [2:0]    op3;
            int            dly;
            isop = ($urandom_range(0, 99) >= 45);
            op3  = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) op3 = 3'd7;
            tmp  = $urandom;
            if (isop)                          tmp = {tmp[31:3], op3};
            else if ($urandom_range(0, 1) == 1) tmp = 32'($urandom_range(0, 20));
            dly  = $urandom_range(0, 3);
            model_apply(isop, tmp, eg, eo);
            send(isop, tmp, dly, got, val, lat, uns);
            check($sformatf("rnd%0d_got", n), got, eg);
            if (eg && got) check($sformatf("rnd%0d_out", n), val, eo);
            check($sformatf("rnd%0d_depth", n), 32'(depth), 32'(mstk.size()));
            check($sformatf("rnd%0d_uf", n), err_underflow, m_uf);
            check($sformatf("rnd%0d_of", n), err_overflow,  m_of);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
